blend_result_collector: RTL and testbench

- Receiving end of the approximate-multiplier image-blending datapath.
- Accepts per-pixel product pairs: image0 pixel times alpha, and image1 pixel times (255-alpha), each 16 bits wide.
- Sums, rounds and saturates each pair to an 8-bit blended pixel, then buffers it in a small FIFO.
- Emits a raster-tagged pixel stream (start-of-frame / end-of-line / end-of-frame) to the frame writer, with per-frame saturation statistics for error analysis of the approximate multipliers.

---
 rtl/blend_pkg.sv | 50 +++++
 rtl/blend_fwft_fifo.sv | 54 +++++
 rtl/blend_result_collector.sv | 175 +++++++++++++++++
 tb/tb_blend_result_collector.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blend_pkg.sv
// Shared widths, raster FIFO entry layout and arithmetic helpers for the blend result collector.
package blend_pkg;

    localparam int unsigned DEF_PROD_W = 16;
    localparam int unsigned DEF_PIX_W  = 8;
    localparam int unsigned DEF_SUM_W  = DEF_PROD_W + 1;
    localparam int unsigned BIAS_W     = DEF_SUM_W + 1;
    localparam int unsigned RND_W      = BIAS_W - DEF_PIX_W;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef struct packed {
        logic [DEF_PIX_W-1:0] pix;
        logic                 sof;
        logic                 eol;
        logic                 eof;
    } pix_entry_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Returns {sat, pixel}; the extra bias bit keeps a carry out of the rounding add visible.
    function automatic logic [DEF_PIX_W:0] round_sat(input logic [DEF_SUM_W-1:0] sum);
        logic [BIAS_W-1:0] biased;
        logic [RND_W-1:0]  r;
        biased = {1'b0, sum} + BIAS_W'(1 << (DEF_PIX_W - 1));
        r      = biased[BIAS_W-1:DEF_PIX_W];
        if (|r[RND_W-1:DEF_PIX_W]) return {1'b1, {DEF_PIX_W{1'b1}}};
        return {1'b0, r[DEF_PIX_W-1:0]};
    endfunction

    // CRC-16-CCITT, MSB-first, one pixel byte per call.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [DEF_PIX_W-1:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = DEF_PIX_W - 1; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/blend_fwft_fifo.sv
// First-word-fall-through FIFO with occupancy count; rdata_o shows the head entry whenever valid_o is high.
module blend_fwft_fifo
    import blend_pkg::*;
#(
    parameter  int unsigned WIDTH = 11,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_pop;

    assign do_pop = pop_i && (count_q != '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            assert (!(push_i && (count_q == CW'(DEPTH))));
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign valid_o = (count_q != '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/blend_result_collector.sv
// Sums, rounds and saturates blend product pairs, buffers them and emits a raster-tagged pixel stream.
// Optional: define BLEND_CRC_EN to add a per-frame CRC-16-CCITT output over handshaked pixels.
module blend_result_collector
    import blend_pkg::*;
#(
    parameter  int unsigned PROD_W     = DEF_PROD_W,
    parameter  int unsigned PIX_W      = DEF_PIX_W,
    parameter  int unsigned IMG_W      = 512,
    parameter  int unsigned IMG_H      = 512,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned SAT_W      = 2 * clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] prod0,
    input  logic [PROD_W-1:0] prod1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_pix,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic              frame_done,
`ifdef BLEND_CRC_EN
    output logic [15:0]       crc,
`endif
    output logic [SAT_W-1:0]  sat_cnt
);

    localparam int unsigned SUM_W   = PROD_W + 1;
    localparam int unsigned XW      = (clog2(IMG_W) > 0) ? clog2(IMG_W) : 1;
    localparam int unsigned YW      = (clog2(IMG_H) > 0) ? clog2(IMG_H) : 1;
    localparam int unsigned CW      = clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OCC_W   = CW + 1;
    localparam int unsigned ENTRY_W = $bits(pix_entry_t);

    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic             accept;
    logic             tag_sof, tag_eol, tag_eof;

    logic             s1_v_q;
    logic [SUM_W-1:0] s1_sum_q;
    logic             s1_sof_q, s1_eol_q, s1_eof_q;

    logic [DEF_PIX_W:0] rs;
    logic               s2_sat;
    pix_entry_t         push_entry;
    pix_entry_t         rd_entry;

    logic             fifo_valid;
    logic [CW-1:0]    fifo_count;
    logic             pop;
    logic [OCC_W-1:0] occ_d;
    logic             in_ready_q, in_ready_d;
    logic [SAT_W-1:0] sat_cnt_q;

    assign accept = in_valid && in_ready_q;

    // Raster position of the pair being accepted this cycle.
    assign tag_sof = (x_q == '0) && (y_q == '0);
    assign tag_eol = (x_q == XW'(IMG_W - 1));
    assign tag_eof = tag_eol && (y_q == YW'(IMG_H - 1));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (accept) begin
            if (tag_eol) begin
                x_d = '0;
                y_d = (y_q == YW'(IMG_H - 1)) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // Stage 1: full-precision sum plus raster tags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q   <= 1'b0;
            s1_sum_q <= '0;
            s1_sof_q <= 1'b0;
            s1_eol_q <= 1'b0;
            s1_eof_q <= 1'b0;
        end else begin
            s1_v_q <= accept;
            if (accept) begin
                s1_sum_q <= SUM_W'(prod0) + SUM_W'(prod1);
                s1_sof_q <= tag_sof;
                s1_eol_q <= tag_eol;
                s1_eof_q <= tag_eof;
            end
        end
    end

    // Stage 2: round/saturate; the FIFO entry itself is the stage-2 register.
    always_comb begin
        rs             = round_sat(s1_sum_q);
        s2_sat         = rs[DEF_PIX_W];
        push_entry.pix = rs[DEF_PIX_W-1:0];
        push_entry.sof = s1_sof_q;
        push_entry.eol = s1_eol_q;
        push_entry.eof = s1_eof_q;
    end

    blend_fwft_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (s1_v_q),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .valid_o (fifo_valid),
        .rdata_o (rd_entry),
        .count_o (fifo_count)
    );

    assign pop        = fifo_valid && out_ready;
    assign out_valid  = fifo_valid;
    assign out_pix    = rd_entry.pix;
    assign out_sof    = rd_entry.sof;
    assign out_eol    = rd_entry.eol;
    assign out_eof    = rd_entry.eof;
    assign frame_done = pop && rd_entry.eof;

    // Credit is computed from next-cycle occupancy so in_ready is a plain register.
    assign occ_d      = OCC_W'(fifo_count) + OCC_W'(s1_v_q) + OCC_W'(accept) - OCC_W'(pop);
    assign in_ready_d = (occ_d < OCC_W'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (!rst_n) in_ready_q <= 1'b0;
        else        in_ready_q <= in_ready_d;
    end

    assign in_ready = in_ready_q;

    // Saturation statistics: restart on the sof pixel, sticky at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else if (s1_v_q) begin
            if (s1_sof_q)                       sat_cnt_q <= SAT_W'(s2_sat);
            else if (s2_sat && (sat_cnt_q != '1)) sat_cnt_q <= sat_cnt_q + SAT_W'(1);
        end
    end

    assign sat_cnt = sat_cnt_q;

`ifdef BLEND_CRC_EN
    logic [15:0] crc_q;

    always_ff @(posedge clk) begin
        if (!rst_n)   crc_q <= CRC16_INIT;
        else if (pop) crc_q <= crc16_byte(out_sof ? CRC16_INIT : crc_q, out_pix);
    end

    assign crc = crc_q;
`endif

endmodule

// File: tb/tb_blend_result_collector.sv
// Directed bench for blend_result_collector on a 4x4 raster; define BLEND_CRC_EN to also exercise crc.
module tb_blend_result_collector;

    localparam int unsigned IMG_W = 4;
    localparam int unsigned IMG_H = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SAT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      prod0;
    logic [15:0]      prod1;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_pix;
    logic             out_sof;
    logic             out_eol;
    logic             out_eof;
    logic             frame_done;
    logic [SAT_W-1:0] sat_cnt;
`ifdef BLEND_CRC_EN
    logic [15:0]      crc;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int fd_pulses   = 0;

    typedef struct {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
        logic       eof;
        logic       fd;
    } hs_t;

    hs_t hs_q[$];

    blend_result_collector #(
        .PROD_W     (16),
        .PIX_W      (8),
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .prod0      (prod0),
        .prod1      (prod1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pix    (out_pix),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .frame_done (frame_done),
`ifdef BLEND_CRC_EN
        .crc        (crc),
`endif
        .sat_cnt    (sat_cnt)
    );

    always #5 clk = ~clk;

    // Record every output handshake mid-cycle, away from the active edge.
    always @(negedge clk) begin
        hs_t h;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            h.pix = out_pix;
            h.sof = out_sof;
            h.eol = out_eol;
            h.eof = out_eof;
            h.fd  = frame_done;
            hs_q.push_back(h);
        end
        if (frame_done === 1'b1) fd_pulses++;
    end

    function automatic logic [7:0] exp_pix(input logic [15:0] a, input logic [15:0] b);
        int unsigned r;
        r = (32'(a) + 32'(b) + 32'd128) / 32'd256;
        return (r > 32'd255) ? 8'hFF : 8'(r);
    endfunction

    function automatic logic [15:0] ref_crc(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        c = c_in ^ {b, 8'h00};
        for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        prod0     = '0;
        prod1     = '0;
        repeat (2) @(posedge clk);
        #1;
        hs_q.delete();
        fd_pulses = 0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] p0, input logic [15:0] p1, input bit rnd);
        bit acc    = 1'b0;
        int budget = 0;
        in_valid = 1'b1;
        prod0    = p0;
        prod1    = p1;
        while (!acc && budget < 300) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget++;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: in_ready got 0 for %0d cycles, required 1", budget);
        end
    endtask

    task automatic drain(input int n, input bit rnd);
        int budget = 0;
        while (hs_q.size() < n && budget < 300) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            #1;
            budget++;
        end
        if (hs_q.size() < n) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pixels, required %0d", hs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        prod0     = 16'hFFFF;
        prod1     = 16'h0100;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        vectors++; if (out_pix !== 8'h00) begin miscompares++; $display("FAIL rst_out_pix: got %h, required 00", out_pix); end
        vectors++; if ({out_sof, out_eol, out_eof} !== 3'b000) begin miscompares++; $display("FAIL rst_tags: got %b, required 000", {out_sof, out_eol, out_eof}); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL rst_frame_done: got %b, required 0", frame_done); end
        vectors++; if (sat_cnt !== 4'd0) begin miscompares++; $display("FAIL rst_sat_cnt: got %0d, required 0", sat_cnt); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
`ifdef BLEND_CRC_EN
        vectors++; if (crc !== 16'hFFFF) begin miscompares++; $display("FAIL rst_crc: got %h, required ffff", crc); end
`endif
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rel_in_ready: got %b, required 1", in_ready); end
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_no_accept: out_valid got %b, required 0", out_valid); end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        prod0     = 16'h4000;
        prod1     = 16'h3F80;
        @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL single_in_ready: got %b, required 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_early: out_valid got %b, required 0 at N+1", out_valid); end
        @(posedge clk);
        #1;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_latency: out_valid got %b, required 1 at N+2", out_valid); end
        vectors++; if (out_pix !== 8'h80) begin miscompares++; $display("FAIL single_pix: got %h, required 80", out_pix); end
        vectors++; if ({out_sof, out_eol, out_eof} !== 3'b100) begin miscompares++; $display("FAIL single_tags: got %b, required 100", {out_sof, out_eol, out_eof}); end
        vectors++; if (sat_cnt !== 4'd0) begin miscompares++; $display("FAIL single_sat_cnt: got %0d, required 0", sat_cnt); end
        @(posedge clk);
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_dup: out_valid got %b, required 0", out_valid); end
    endtask

    task automatic test_rounding();
        logic [15:0] a[4]   = '{16'h4000, 16'hFFFF, 16'h0000, 16'h0000};
        logic [15:0] b[4]   = '{16'h3F80, 16'h0100, 16'h007F, 16'h0080};
        logic [7:0]  exp[4] = '{8'h80, 8'hFF, 8'h00, 8'h01};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(a[i], b[i], 1'b0);
        in_valid = 1'b0;
        drain(4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (hs_q[i].pix !== exp[i]) begin miscompares++; $display("FAIL round_pix[%0d]: got %h, required %h", i, hs_q[i].pix, exp[i]); end
            vectors++;
            if ({hs_q[i].sof, hs_q[i].eol} !== {i == 0, i == 3}) begin
                miscompares++; $display("FAIL round_tags[%0d]: got sof/eol %b%b, required %b%b", i, hs_q[i].sof, hs_q[i].eol, i == 0, i == 3);
            end
        end
        vectors++; if (sat_cnt !== 4'd1) begin miscompares++; $display("FAIL round_sat_cnt: got %0d, required 1", sat_cnt); end
    endtask

    task automatic test_backpressure();
        int acc_cnt = 0;
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 12; c++) begin
            prod0 = 16'(16'h1000 * (acc_cnt + 1));
            prod1 = 16'h0000;
            @(negedge clk);
            if (in_ready) acc_cnt++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        vectors++; if (acc_cnt != int'(DEPTH)) begin miscompares++; $display("FAIL bp_accepts: got %0d, required %0d", acc_cnt, DEPTH); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
        vectors++; if ({out_valid, out_pix, out_sof} !== {1'b1, 8'h10, 1'b1}) begin
            miscompares++; $display("FAIL bp_hold: got valid/pix/sof %b/%h/%b, required 1/10/1", out_valid, out_pix, out_sof);
        end
        drain(4, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (hs_q.size() != 4) begin miscompares++; $display("FAIL bp_count: got %0d pixels, required 4", hs_q.size()); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (hs_q[i].pix !== 8'(8'h10 * (i + 1))) begin miscompares++; $display("FAIL bp_order[%0d]: got %h, required %h", i, hs_q[i].pix, 8'(8'h10 * (i + 1))); end
        end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_recover: in_ready got %b, required 1", in_ready); end
    endtask

    task automatic test_frame();
        logic [15:0] a[20];
        logic [15:0] b[20];
        logic [3:0]  exp_tags;
        int          pos;
        for (int i = 0; i < 16; i++) begin
            if (i == 2 || i == 7 || i == 12) begin a[i] = 16'hFFFF; b[i] = 16'h0200; end
            else begin a[i] = 16'(i * 16'h0A00); b[i] = 16'(i * 16'h0031); end
        end
        a[16] = 16'h1234; b[16] = 16'h0100;
        a[17] = 16'hFFFF; b[17] = 16'h0200;
        a[18] = 16'h2000; b[18] = 16'h0000;
        a[19] = 16'h2000; b[19] = 16'h0000;
        do_reset();
        for (int i = 0; i < 16; i++) send(a[i], b[i], 1'b1);
        in_valid = 1'b0;
        drain(16, 1'b1);
        vectors++; if (fd_pulses != 1) begin miscompares++; $display("FAIL frame_done_count: got %0d, required 1", fd_pulses); end
        vectors++; if (sat_cnt !== 4'd3) begin miscompares++; $display("FAIL frame_sat_cnt: got %0d, required 3", sat_cnt); end
        for (int i = 16; i < 20; i++) send(a[i], b[i], 1'b1);
        in_valid = 1'b0;
        drain(20, 1'b1);
        for (int i = 0; i < 20; i++) begin
            pos      = i % 16;
            exp_tags = {pos == 0, (pos % 4) == 3, pos == 15, pos == 15};
            vectors++;
            if (hs_q[i].pix !== exp_pix(a[i], b[i])) begin miscompares++; $display("FAIL frame_pix[%0d]: got %h, required %h", i, hs_q[i].pix, exp_pix(a[i], b[i])); end
            vectors++;
            if ({hs_q[i].sof, hs_q[i].eol, hs_q[i].eof, hs_q[i].fd} !== exp_tags) begin
                miscompares++; $display("FAIL frame_tags[%0d]: got sof/eol/eof/fd %b%b%b%b, required %b", i, hs_q[i].sof, hs_q[i].eol, hs_q[i].eof, hs_q[i].fd, exp_tags);
            end
        end
        vectors++; if (fd_pulses != 1) begin miscompares++; $display("FAIL frame_done_total: got %0d, required 1", fd_pulses); end
        vectors++; if (sat_cnt !== 4'd1) begin miscompares++; $display("FAIL frame2_sat_cnt: got %0d, required 1", sat_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) send((i == 1) ? 16'hFFFF : 16'h3000, (i == 1) ? 16'h0100 : 16'h0000, 1'b0);
        in_valid = 1'b0;
        drain(6, 1'b0);
        vectors++; if (sat_cnt !== 4'd1) begin miscompares++; $display("FAIL mid_sat_cnt: got %0d, required 1", sat_cnt); end
        out_ready = 1'b0;
        send(16'h5000, 16'h0000, 1'b0);
        send(16'h6000, 16'h0000, 1'b0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pending: out_valid got %b, required 1", out_valid); end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if ({out_valid, out_pix} !== 9'h000) begin miscompares++; $display("FAIL mid_rst_out: got valid/pix %b/%h, required 0/00", out_valid, out_pix); end
        vectors++; if ({out_sof, out_eol, out_eof, frame_done} !== 4'b0000) begin miscompares++; $display("FAIL mid_rst_tags: got %b, required 0000", {out_sof, out_eol, out_eof, frame_done}); end
        vectors++; if (sat_cnt !== 4'd0) begin miscompares++; $display("FAIL mid_rst_sat_cnt: got %0d, required 0", sat_cnt); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_rst_in_ready: got %b, required 0", in_ready); end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_discard: out_valid got %b, required 0", out_valid); end
        hs_q.delete();
        send(16'h4000, 16'h3F80, 1'b0);
        in_valid = 1'b0;
        drain(1, 1'b0);
        vectors++; if ({hs_q[0].pix, hs_q[0].sof, hs_q[0].eol} !== {8'h80, 1'b1, 1'b0}) begin
            miscompares++; $display("FAIL mid_restart: got pix/sof/eol %h/%b/%b, required 80/1/0", hs_q[0].pix, hs_q[0].sof, hs_q[0].eol);
        end
        vectors++; if (sat_cnt !== 4'd0) begin miscompares++; $display("FAIL mid_restart_sat: got %0d, required 0", sat_cnt); end
    endtask

`ifdef BLEND_CRC_EN
    task automatic test_crc();
        logic [15:0] golden = 16'hFFFF;
        for (int i = 0; i < 16; i++) golden = ref_crc(golden, 8'h80);
        do_reset();
        for (int i = 0; i < 16; i++) send(16'h4000, 16'h3F80, 1'b1);
        in_valid = 1'b0;
        drain(16, 1'b1);
        vectors++; if (crc !== golden) begin miscompares++; $display("FAIL crc_frame: got %h, required %h", crc, golden); end
        repeat (5) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        vectors++; if (crc !== golden) begin miscompares++; $display("FAIL crc_hold: got %h, required %h", crc, golden); end
        vectors++; if (fd_pulses != 1) begin miscompares++; $display("FAIL crc_frame_done: got %0d, required 1", fd_pulses); end
        send(16'h4000, 16'h3F80, 1'b0);
        in_valid = 1'b0;
        drain(17, 1'b0);
        vectors++; if (crc !== ref_crc(16'hFFFF, 8'h80)) begin miscompares++; $display("FAIL crc_restart: got %h, required %h", crc, ref_crc(16'hFFFF, 8'h80)); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        prod0     = '0;
        prod1     = '0;
        test_reset();
        test_single();
        test_rounding();
        test_backpressure();
        test_frame();
        test_reset_mid_frame();
`ifdef BLEND_CRC_EN
        test_crc();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
